// File: rtl/spi_stream_fifo.sv
// spi_stream_fifo
//   Byte FIFO that streams producer data (status/metadata, debug capture) to
//   the MCU over SPI. It sits downstream of spi_peripheral, decodes the
//   current opcode and returns bytes on one response/valid pair.
//   The write side shares the SPI peripheral clock.
//
// Ports
//   clock_in            spi_peripheral clock
//   reset_n_in          asynchronous active-low reset
//   opcode_in           current SPI opcode
//   opcode_valid_in     high for the SPI transaction after the opcode byte
//   operand_valid_in    level; each rising edge marks one operand byte clocked
//   operand_count_in    index of the current operand byte
//   response_out        byte returned to spi_peripheral
//   response_valid_out  response_out is valid for this transaction
//   write_data_in       producer byte
//   write_valid_in      producer strobe
//   write_ready_out     high while the FIFO is not full
//
// Opcodes
//   READ_ADDRESS   pop one byte per operand strobe (0x00 when empty)
//   COUNT_ADDRESS  16-bit status {overflow, fill count}, MSB byte first
//   CLEAR_ADDRESS  flush FIFO and clear the overflow flag
module spi_stream_fifo #(
  parameter logic [7:0]  READ_ADDRESS  = 8'h30,
  parameter logic [7:0]  COUNT_ADDRESS = 8'h31,
  parameter logic [7:0]  CLEAR_ADDRESS = 8'h32,
  parameter int unsigned DEPTH         = 256,
  parameter int unsigned ADDR_WIDTH    = $clog2(DEPTH)
) (
  input  logic        clock_in,
  input  logic        reset_n_in,
  input  logic [7:0]  opcode_in,
  input  logic        opcode_valid_in,
  input  logic        operand_valid_in,
  input  logic [31:0] operand_count_in,
  output logic [7:0]  response_out,
  output logic        response_valid_out,
  input  logic [7:0]  write_data_in,
  input  logic        write_valid_in,
  output logic        write_ready_out
);

  localparam int unsigned PW = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_COUNT
  } state_t;

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          overflow_q, overflow_d;
  logic          opv_q, opv_prev_q;
  logic          orv_q, orv_prev_q;
  state_t        state_q, state_d;
  logic [15:0]   status_q, status_d;
  logic [7:0]    resp_q, resp_d;
  logic          resp_valid_q, resp_valid_d;

  logic          empty;
  logic          full;
  logic [PW-1:0] count;
  logic [7:0]    head;
  logic [15:0]   status_live;
  logic          opcode_edge;
  logic          operand_edge;
  logic          do_clear;
  logic          do_pop;
  logic          do_push;

  assign empty        = (wr_ptr_q == rd_ptr_q);
  assign full         = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                        (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);
  assign count        = wr_ptr_q - rd_ptr_q;
  assign head         = empty ? '0 : mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
  // count is at most 15 bits wide, so bit 15 is free for the overflow flag
  assign status_live  = 16'(count) | {overflow_q, 15'b0};
  assign opcode_edge  = opv_q && !opv_prev_q;
  assign operand_edge = orv_q && !orv_prev_q;

  assign write_ready_out    = !full;
  assign response_out       = resp_q;
  assign response_valid_out = resp_valid_q;

  // FSM next state and response byte
  always_comb begin
    state_d      = state_q;
    status_d     = status_q;
    resp_d       = '0;
    resp_valid_d = 1'b0;
    do_clear     = 1'b0;
    do_pop       = 1'b0;
    if (!opv_q) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (opcode_edge) begin
            if (opcode_in == READ_ADDRESS) begin
              state_d      = ST_READ;
              resp_valid_d = 1'b1;
              resp_d       = head;
            end else if (opcode_in == COUNT_ADDRESS) begin
              state_d      = ST_COUNT;
              status_d     = status_live;
              resp_valid_d = 1'b1;
              resp_d       = (operand_count_in == '0) ? status_live[15:8]
                                                      : status_live[7:0];
            end else if (opcode_in == CLEAR_ADDRESS) begin
              do_clear = 1'b1;
            end
          end
        end
        ST_READ: begin
          resp_valid_d = 1'b1;
          resp_d       = head;
          do_pop       = operand_edge && !empty;
        end
        ST_COUNT: begin
          resp_valid_d = 1'b1;
          resp_d       = (operand_count_in == '0) ? status_q[15:8] : status_q[7:0];
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // A pop in the same cycle frees a slot, so a push into a full FIFO is
  // still accepted then; a clear discards any concurrent write.
  assign do_push = write_valid_in && !do_clear && (!full || do_pop);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    if (do_clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      overflow_d = 1'b0;
    end else begin
      if (do_pop) rd_ptr_d = rd_ptr_q + PW'(1);
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (write_valid_in && full && !do_pop) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      overflow_q   <= 1'b0;
      opv_q        <= 1'b0;
      opv_prev_q   <= 1'b0;
      orv_q        <= 1'b0;
      orv_prev_q   <= 1'b0;
      state_q      <= ST_IDLE;
      status_q     <= '0;
      resp_q       <= '0;
      resp_valid_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      overflow_q   <= overflow_d;
      opv_q        <= opcode_valid_in;
      opv_prev_q   <= opv_q;
      orv_q        <= operand_valid_in;
      orv_prev_q   <= orv_q;
      state_q      <= state_d;
      status_q     <= status_d;
      resp_q       <= resp_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  // Storage is not reset; the pointers define what is valid.
  always_ff @(posedge clock_in) begin
    if (do_push) mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= write_data_in;
  end

endmodule
